// File: rtl/mips_hazard_pkg.sv
// Shared constants and types for the MIPS32 forwarding / hazard unit.
package mips_hazard_pkg;

  // Architectural register address width; r0 is hard-wired to zero.
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Forward-select encoding: 0 reads the register file, k selects stage k.
  localparam int FWD_RF = 0;

  // Scoreboard slot occupancy.
  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_BUSY = 1'b1
  } slot_state_e;

endpackage

// File: rtl/mdu_scoreboard_slot.sv
// Single-entry countdown scoreboard tracking one in-flight multi-cycle MDU write.
module mdu_scoreboard_slot
  import mips_hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int AW      = REG_AW,
  parameter int LAT_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_i,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic [LAT_W-1:0]      issue_lat_i,
  input  logic [NUM_SRC*AW-1:0] src_addr_i,
  input  logic [NUM_SRC-1:0]    src_used_i,
  output logic                  busy_o,
  output logic                  match_o
);

  slot_state_e      state_q;
  logic [AW-1:0]    rd_q;
  logic [LAT_W-1:0] cnt_q;

  // Slot FSM: a new issue always (re)loads the slot, even on the release
  // cycle or while still busy; otherwise count down and free at cnt == 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_IDLE;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else if (issue_i) begin
      state_q <= SLOT_BUSY;
      rd_q    <= issue_rd_i;
      cnt_q   <= (issue_lat_i == '0) ? LAT_W'(1) : issue_lat_i;
    end else if (state_q == SLOT_BUSY) begin
      if (cnt_q == LAT_W'(1)) begin
        state_q <= SLOT_IDLE;
        rd_q    <= '0;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q - LAT_W'(1);
      end
    end
  end

  assign busy_o = (state_q == SLOT_BUSY);

  // Any used ID source reading the pending destination (r0 never matches).
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used_i[i] && (src_addr_i[i*AW +: AW] == rd_q) &&
          (rd_q != AW'(REG_ZERO))) begin
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select generation, load-use / MDU stall detection and
// saturating performance counters for the 5-stage MIPS32 pipeline.
module hazard_forward_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int AW         = REG_AW,
  parameter int LAT_W      = 4,
  parameter int CNT_W      = 32,
  localparam int SELW      = $clog2(FWD_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_SRC*AW-1:0]    ex_src_addr,
  input  logic [NUM_SRC-1:0]       ex_src_used,
  input  logic [FWD_STAGES-1:0]    stage_regwrite,
  input  logic [FWD_STAGES*AW-1:0] stage_rd,
  input  logic                     ex_valid,
  input  logic                     ex_memread,
  input  logic [AW-1:0]            ex_rd,
  input  logic                     id_valid,
  input  logic [NUM_SRC*AW-1:0]    id_src_addr,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic                     id_mdu_op,
  input  logic                     mdu_issue,
  input  logic [AW-1:0]            mdu_rd,
  input  logic [LAT_W-1:0]         mdu_lat,
  output logic [NUM_SRC*SELW-1:0]  fwd_sel,
  output logic                     stall,
  output logic                     mdu_busy,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         fwd_cnt
);

  logic             load_use;
  logic             mdu_hazard;
  logic             slot_match;
  logic             any_fwd;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] fwd_cnt_q;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Per-operand priority encoder: scan oldest to youngest so the youngest
  // matching stage overwrites and wins.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [SELW-1:0] sel;

    // Select the youngest stage writing this operand's register.
    always_comb begin
      sel = SELW'(FWD_RF);
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (ex_src_used[g] && stage_regwrite[k-1] &&
            (stage_rd[(k-1)*AW +: AW] == ex_src_addr[g*AW +: AW]) &&
            (ex_src_addr[g*AW +: AW] != AW'(REG_ZERO))) begin
          sel = SELW'(k);
        end
      end
    end

    assign fwd_sel[g*SELW +: SELW] = sel;
  end

  assign any_fwd = |fwd_sel;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_valid && ex_valid && ex_memread && (ex_rd != AW'(REG_ZERO)) &&
          id_src_used[i] && (id_src_addr[i*AW +: AW] == ex_rd)) begin
        load_use = 1'b1;
      end
    end
  end

  mdu_scoreboard_slot #(
    .NUM_SRC (NUM_SRC),
    .AW      (AW),
    .LAT_W   (LAT_W)
  ) u_slot (
    .clk         (clk),
    .rst         (rst),
    .issue_i     (mdu_issue),
    .issue_rd_i  (mdu_rd),
    .issue_lat_i (mdu_lat),
    .src_addr_i  (id_src_addr),
    .src_used_i  (id_src_used),
    .busy_o      (mdu_busy),
    .match_o     (slot_match)
  );

  // A second MDU op also waits: the single slot cannot track two writers.
  assign mdu_hazard = id_valid && mdu_busy && (slot_match || id_mdu_op);

  // A squashed ID instruction never needs to wait.
  assign stall = (load_use || mdu_hazard) && !flush;

  // Saturating stall / forward activity counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall)   stall_cnt_q <= sat_inc(stall_cnt_q);
      if (any_fwd) fwd_cnt_q   <= sat_inc(fwd_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard-driven bench for hazard_forward_ctrl (4-bit counters so
// saturation is reachable quickly).
module tb_hazard_forward_ctrl;

  localparam int NS = 2;
  localparam int FS = 2;
  localparam int AW = 5;
  localparam int LW = 4;
  localparam int CW = 4;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [NS*AW-1:0]  ex_src_addr;
  logic [NS-1:0]     ex_src_used;
  logic [FS-1:0]     stage_regwrite;
  logic [FS*AW-1:0]  stage_rd;
  logic              ex_valid;
  logic              ex_memread;
  logic [AW-1:0]     ex_rd;
  logic              id_valid;
  logic [NS*AW-1:0]  id_src_addr;
  logic [NS-1:0]     id_src_used;
  logic              id_mdu_op;
  logic              mdu_issue;
  logic [AW-1:0]     mdu_rd;
  logic [LW-1:0]     mdu_lat;
  logic [NS*SW-1:0]  fwd_sel;
  logic              stall;
  logic              mdu_busy;
  logic [CW-1:0]     stall_cnt;
  logic [CW-1:0]     fwd_cnt;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(
    .NUM_SRC    (NS),
    .FWD_STAGES (FS),
    .AW         (AW),
    .LAT_W      (LW),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ex_src_addr    (ex_src_addr),
    .ex_src_used    (ex_src_used),
    .stage_regwrite (stage_regwrite),
    .stage_rd       (stage_rd),
    .ex_valid       (ex_valid),
    .ex_memread     (ex_memread),
    .ex_rd          (ex_rd),
    .id_valid       (id_valid),
    .id_src_addr    (id_src_addr),
    .id_src_used    (id_src_used),
    .id_mdu_op      (id_mdu_op),
    .mdu_issue      (mdu_issue),
    .mdu_rd         (mdu_rd),
    .mdu_lat        (mdu_lat),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .mdu_busy       (mdu_busy),
    .stall_cnt      (stall_cnt),
    .fwd_cnt        (fwd_cnt)
  );

  typedef struct {
    logic            rst, flush;
    logic [NS*AW-1:0] exs;
    logic [NS-1:0]   exu;
    logic [FS-1:0]   wr;
    logic [FS*AW-1:0] srd;
    logic            exv, exm;
    logic [AW-1:0]   exrd;
    logic            idv;
    logic [NS*AW-1:0] ids;
    logic [NS-1:0]   idu;
    logic            mduop, iss;
    logic [AW-1:0]   mrd;
    logic [LW-1:0]   lat;
    logic [NS*SW-1:0] xfwd;
    logic            xst, xbz;
  } vec_t;

  typedef struct {
    logic [NS*SW-1:0] fwd;
    logic             stall;
    logic             busy;
    logic [CW-1:0]    scnt;
    logic [CW-1:0]    fcnt;
  } exp_t;

  exp_t          q[$];
  int            vec_cnt = 0;
  int            err_cnt = 0;
  logic [CW-1:0] m_scnt = '0;
  logic [CW-1:0] m_fcnt = '0;

  function automatic vec_t idle_v();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    rst            = v.rst;
    flush          = v.flush;
    ex_src_addr    = v.exs;
    ex_src_used    = v.exu;
    stage_regwrite = v.wr;
    stage_rd       = v.srd;
    ex_valid       = v.exv;
    ex_memread     = v.exm;
    ex_rd          = v.exrd;
    id_valid       = v.idv;
    id_src_addr    = v.ids;
    id_src_used    = v.idu;
    id_mdu_op      = v.mduop;
    mdu_issue      = v.iss;
    mdu_rd         = v.mrd;
    mdu_lat        = v.lat;
  endtask

  // Expected counters show the activity of all earlier cycles; they then
  // advance (or clear on reset) for the next vector.
  task automatic push_exp(input logic [NS*SW-1:0] fwd, input logic st, input logic bz);
    exp_t e;
    e.fwd = fwd; e.stall = st; e.busy = bz; e.scnt = m_scnt; e.fcnt = m_fcnt;
    q.push_back(e);
    if (rst) begin
      m_scnt = '0;
      m_fcnt = '0;
    end else begin
      if (st && m_scnt != 4'hF) m_scnt = m_scnt + 4'd1;
      if (fwd != '0 && m_fcnt != 4'hF) m_fcnt = m_fcnt + 4'd1;
    end
  endtask

  task automatic drive(input vec_t v);
    set_inputs(v);
    push_exp(v.xfwd, v.xst, v.xbz);
  endtask

  task automatic test_reset();
    vec_t v;
    exp_t e;
    v = idle_v();
    v.rst = 1'b1;
    drive(v);
    @(negedge clk);
    vec_cnt++;
    e = q.pop_front();
    if (fwd_sel !== e.fwd || stall !== e.stall || mdu_busy !== e.busy ||
        stall_cnt !== e.scnt || fwd_cnt !== e.fcnt) begin
      err_cnt++;
      $display("FAIL reset: fwd=%b stall=%b busy=%b scnt=%0d fcnt=%0d, want %b %b %b %0d %0d",
               fwd_sel, stall, mdu_busy, stall_cnt, fwd_cnt, e.fwd, e.stall, e.busy, e.scnt, e.fcnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward();
    vec_t v;
    vec_t tbl[$];
    exp_t e;
    v = idle_v();
    v.exs = {5'd0, 5'd3}; v.exu = 2'b11; v.wr = 2'b11; v.srd = {5'd3, 5'd3};
    v.xfwd = 4'b0001; tbl.push_back(v);          // both stages hit r3: youngest wins
    v.srd = {5'd3, 5'd0}; v.xfwd = 4'b0010; tbl.push_back(v);  // stage1 writes r0: ignored
    v.exs = {5'd4, 5'd3}; v.srd = {5'd3, 5'd4};
    v.xfwd = 4'b0110; tbl.push_back(v);          // src0 from stage2, src1 from stage1
    v.exu = 2'b01; v.xfwd = 4'b0010; tbl.push_back(v);         // src1 not read
    v.exs = {5'd4, 5'd4}; v.exu = 2'b11; v.wr = 2'b10; v.srd = {5'd4, 5'd4};
    v.xfwd = 4'b1010; tbl.push_back(v);          // only stage2 writes
    v.wr = 2'b00; v.xfwd = 4'b0000; tbl.push_back(v);          // nobody writes
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      vec_cnt++;
      e = q.pop_front();
      if (fwd_sel !== e.fwd || stall !== e.stall || mdu_busy !== e.busy ||
          stall_cnt !== e.scnt || fwd_cnt !== e.fcnt) begin
        err_cnt++;
        $display("FAIL forward[%0d]: fwd=%b stall=%b busy=%b scnt=%0d fcnt=%0d, want %b %b %b %0d %0d",
                 i, fwd_sel, stall, mdu_busy, stall_cnt, fwd_cnt, e.fwd, e.stall, e.busy, e.scnt, e.fcnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    vec_t v;
    vec_t tbl[$];
    exp_t e;
    v = idle_v();
    v.exv = 1'b1; v.exm = 1'b1; v.exrd = 5'd5; v.idv = 1'b1;
    v.ids = {5'd5, 5'd0}; v.idu = 2'b10; v.xst = 1'b1; tbl.push_back(v);
    v.flush = 1'b1; v.xst = 1'b0; tbl.push_back(v);            // flushed: no stall
    v.flush = 1'b0; v.idu = 2'b01; tbl.push_back(v);           // r5 operand unused
    v.idu = 2'b10; v.exm = 1'b0; tbl.push_back(v);             // not a load
    v.exm = 1'b1; v.idv = 1'b0; tbl.push_back(v);              // ID empty
    v.idv = 1'b1; v.exrd = 5'd0; v.ids = {5'd0, 5'd0}; v.idu = 2'b11;
    tbl.push_back(v);                                          // load to r0
    v.exrd = 5'd5; v.ids = {5'd5, 5'd0}; v.idu = 2'b10; v.exv = 1'b0;
    tbl.push_back(v);                                          // EX bubble
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      vec_cnt++;
      e = q.pop_front();
      if (fwd_sel !== e.fwd || stall !== e.stall || mdu_busy !== e.busy ||
          stall_cnt !== e.scnt || fwd_cnt !== e.fcnt) begin
        err_cnt++;
        $display("FAIL load_use[%0d]: fwd=%b stall=%b busy=%b scnt=%0d fcnt=%0d, want %b %b %b %0d %0d",
                 i, fwd_sel, stall, mdu_busy, stall_cnt, fwd_cnt, e.fwd, e.stall, e.busy, e.scnt, e.fcnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mdu();
    vec_t v;
    vec_t r;
    vec_t tbl[$];
    exp_t e;
    v = idle_v(); v.iss = 1'b1; v.mrd = 5'd8; v.lat = 4'd3; tbl.push_back(v);
    r = idle_v(); r.idv = 1'b1; r.ids = {5'd0, 5'd8}; r.idu = 2'b01;
    r.xst = 1'b1; r.xbz = 1'b1;
    tbl.push_back(r); tbl.push_back(r); tbl.push_back(r);      // three stall cycles
    r.xst = 1'b0; r.xbz = 1'b0; tbl.push_back(r);              // released: read RF
    v = idle_v(); v.iss = 1'b1; v.mrd = 5'd9; v.lat = 4'd2; tbl.push_back(v);
    v = idle_v(); v.idv = 1'b1; v.mduop = 1'b1; v.ids = {5'd1, 5'd2}; v.idu = 2'b11;
    v.xst = 1'b1; v.xbz = 1'b1; tbl.push_back(v);              // second MDU op waits
    v = idle_v(); v.idv = 1'b1; v.flush = 1'b1; v.ids = {5'd9, 5'd0}; v.idu = 2'b10;
    v.xbz = 1'b1; tbl.push_back(v);                            // flush gates stall only
    v.flush = 1'b0; v.xbz = 1'b0; tbl.push_back(v);            // op still completed
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      vec_cnt++;
      e = q.pop_front();
      if (fwd_sel !== e.fwd || stall !== e.stall || mdu_busy !== e.busy ||
          stall_cnt !== e.scnt || fwd_cnt !== e.fcnt) begin
        err_cnt++;
        $display("FAIL mdu[%0d]: fwd=%b stall=%b busy=%b scnt=%0d fcnt=%0d, want %b %b %b %0d %0d",
                 i, fwd_sel, stall, mdu_busy, stall_cnt, fwd_cnt, e.fwd, e.stall, e.busy, e.scnt, e.fcnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t v;
    vec_t tbl[$];
    exp_t e;
    v = idle_v(); v.iss = 1'b1; v.mrd = 5'd10; v.lat = 4'd0; tbl.push_back(v);
    v = idle_v(); v.idv = 1'b1; v.ids = {5'd0, 5'd10}; v.idu = 2'b01;
    v.xst = 1'b1; v.xbz = 1'b1; tbl.push_back(v);              // latency 0 -> one cycle
    v.xst = 1'b0; v.xbz = 1'b0; tbl.push_back(v);
    v = idle_v(); v.iss = 1'b1; v.mrd = 5'd10; v.lat = 4'd0; tbl.push_back(v);
    v = idle_v(); v.idv = 1'b1; v.ids = {5'd0, 5'd10}; v.idu = 2'b01;
    v.iss = 1'b1; v.mrd = 5'd11; v.lat = 4'd2;
    v.xst = 1'b1; v.xbz = 1'b1; tbl.push_back(v);              // reissue on release cycle
    v.iss = 1'b0; v.xst = 1'b0; tbl.push_back(v);              // r10 no longer tracked
    v.ids = {5'd0, 5'd11}; v.xst = 1'b1; tbl.push_back(v);     // r11 tracked
    v.xst = 1'b0; v.xbz = 1'b0; tbl.push_back(v);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      vec_cnt++;
      e = q.pop_front();
      if (fwd_sel !== e.fwd || stall !== e.stall || mdu_busy !== e.busy ||
          stall_cnt !== e.scnt || fwd_cnt !== e.fcnt) begin
        err_cnt++;
        $display("FAIL back_to_back[%0d]: fwd=%b stall=%b busy=%b scnt=%0d fcnt=%0d, want %b %b %b %0d %0d",
                 i, fwd_sel, stall, mdu_busy, stall_cnt, fwd_cnt, e.fwd, e.stall, e.busy, e.scnt, e.fcnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    vec_t tbl[$];
    exp_t e;
    v = idle_v(); v.iss = 1'b1; v.mrd = 5'd12; v.lat = 4'd6; tbl.push_back(v);
    v = idle_v(); v.xbz = 1'b1; tbl.push_back(v);              // cnt = 6
    v.rst = 1'b1; tbl.push_back(v);                            // reset with cnt = 5
    v = idle_v(); v.idv = 1'b1; v.ids = {5'd0, 5'd12}; v.idu = 2'b01;
    tbl.push_back(v);                                          // pending op dropped
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      vec_cnt++;
      e = q.pop_front();
      if (fwd_sel !== e.fwd || stall !== e.stall || mdu_busy !== e.busy ||
          stall_cnt !== e.scnt || fwd_cnt !== e.fcnt) begin
        err_cnt++;
        $display("FAIL reset_mid[%0d]: fwd=%b stall=%b busy=%b scnt=%0d fcnt=%0d, want %b %b %b %0d %0d",
                 i, fwd_sel, stall, mdu_busy, stall_cnt, fwd_cnt, e.fwd, e.stall, e.busy, e.scnt, e.fcnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    vec_t v;
    vec_t tbl[$];
    exp_t e;
    v = idle_v();
    v.exv = 1'b1; v.exm = 1'b1; v.exrd = 5'd5; v.idv = 1'b1;
    v.ids = {5'd5, 5'd0}; v.idu = 2'b10; v.xst = 1'b1;
    v.exs = {5'd0, 5'd7}; v.exu = 2'b01; v.wr = 2'b01; v.srd = {5'd0, 5'd7};
    v.xfwd = 4'b0001;
    for (int n = 0; n < 20; n++) tbl.push_back(v);
    tbl.push_back(idle_v());                                   // both counters at 15
    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      vec_cnt++;
      e = q.pop_front();
      if (fwd_sel !== e.fwd || stall !== e.stall || mdu_busy !== e.busy ||
          stall_cnt !== e.scnt || fwd_cnt !== e.fcnt) begin
        err_cnt++;
        $display("FAIL saturation[%0d]: fwd=%b stall=%b busy=%b scnt=%0d fcnt=%0d, want %b %b %b %0d %0d",
                 i, fwd_sel, stall, mdu_busy, stall_cnt, fwd_cnt, e.fwd, e.stall, e.busy, e.scnt, e.fcnt);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t v0;
    v0 = idle_v();
    v0.rst = 1'b1;
    set_inputs(v0);
    @(posedge clk); #1;
    test_reset();
    test_forward();
    test_load_use();
    test_mdu();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    if (q.size() != 0) begin
      err_cnt++;
      $display("FAIL leftover: %0d expected entries never compared, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bench did not complete");
    $fatal(1);
  end

endmodule
